ldst_exunit: RTL and testbench
==============================

// Module: ldst_exunit
// PURPOSE
//  Load/store execution unit; consumes operands issued from the load/store reservation station.
//  Address = rs1 + imm. Word-only accesses (RV32 LW/SW); addr[1:0] ignored.
//  Stores: held in an in-order store buffer until committed, then drained to dmem.
//  Loads: read dmem with forwarding from the store buffer; result broadcast on the ld exfin bus.
// PARAMETERS
//  SB_ENT_NUM  4  store-buffer depth (power of 2)
//  SB_ENT_SEL  2  log2(SB_ENT_NUM)
// PORTS
//  clk               in   1                  clock
//  rst_n             in   1                  reset: synchronous, active-low
//  i_issue_vld       in   1                  RS issues one ld/st this cycle
//  o_issue_rdy       out  1                  unit can accept an issue (= sb count < SB_ENT_NUM)
//  i_rs1_srcopr      in   RV32_DATA_WIDTH    base address operand
//  i_rs2_srcopr      in   RV32_DATA_WIDTH    store data operand
//  i_imm             in   RV32_DATA_WIDTH    address offset
//  i_is_st           in   1                  1 = store, 0 = load
//  i_rrftag          in   RRF_ENT_SEL        destination/ROB tag
//  i_com_st          in   1                  oldest uncommitted store retires this cycle
//  o_dmem_rd_en      out  1                  dmem read request; data is valid next cycle
//  o_dmem_wr_en      out  1                  dmem write (drain)
//  o_dmem_addr       out  RV32_DATA_WIDTH    shared single-port address
//  o_dmem_wdata      out  RV32_DATA_WIDTH    drain write data
//  i_dmem_rdata      in   RV32_DATA_WIDTH    read data, 1 cycle after o_dmem_rd_en
//  o_exfin_ld        out  1                  load result valid
//  o_ex_ld_rrftag    out  RRF_ENT_SEL        load tag
//  o_exfin_ld_res    out  RV32_DATA_WIDTH    load result
//  o_exfin_st        out  1                  store placed in buffer (complete for ROB)
//  o_ex_st_rrftag    out  RRF_ENT_SEL        store tag
// BEHAVIOUR
//  - Reset: all outputs 0 except o_issue_rdy = 1; sb count, committed count, head and tail = 0.
//    Reset mid-operation discards all entries, including committed ones, with no dmem write.
//  - Accept = i_issue_vld & o_issue_rdy. Issuing while rdy = 0 is illegal (assertion).
//  - Store accept: push {addr, rs2} at tail. Next cycle: o_exfin_st = 1 with the tag.
//  - Load accept: o_dmem_rd_en = 1 and o_dmem_addr = addr in the same cycle.
//    - Search the store buffer in the same cycle: compare addr[31:2] against all valid entries
//      (committed or not). The youngest match wins (scan from tail-1 toward head).
//    - Register the hit flag, forwarded data and tag.
//    - Next cycle: o_exfin_ld = 1, o_exfin_ld_res = hit ? fwd_data : i_dmem_rdata.
//  - Load latency is exactly 1 cycle. exfin pulses last exactly 1 cycle each.
//  - Commit: i_com_st increments the committed count.
//    - i_com_st with no uncommitted entry is illegal; it is ignored and flagged by an assertion.
//  - Drain condition: committed count > 0 AND no load accepted this cycle (loads own the port).
//    - On drain, o_dmem_wr_en = 1, addr/wdata come from the head entry.
//    - Head, count and committed count decrement at the clock edge.
//    - Store accept and drain in the same cycle is legal; count is unchanged.
//  - i_com_st and drain in the same cycle: committed count is unchanged.
//    A commit becomes drain-eligible the following cycle.
//  - Full: count == SB_ENT_NUM drops o_issue_rdy, which blocks loads as well.
//    Drains then proceed, which guarantees forward progress.
//  - Pointers wrap modulo SB_ENT_NUM. o_dmem_rd_en and o_dmem_wr_en are never both 1.
//  - No speculative kill in this unit; uncommitted stores leave only via commit or reset.
// STRUCTURE
//  - constants.vh: add SB_ENT_NUM and SB_ENT_SEL.
//    Reuses RV32_DATA_WIDTH and RRF_ENT_SEL.
//  - Sub-module store_buffer holds: storage, head/tail/count/committed-count, the youngest-match
//    forward search, and the drain outputs.
//  - ldst_exunit holds: the address adder, port arbitration, and the exfin output registers.
// TESTING
//  1. St rs1=0x100 imm=4 rs2=0xDEADBEEF tag=3 -> next cycle exfin_st=1 tag=3.
//     Then ld rs1=0x104 imm=0 tag=5 -> next cycle exfin_ld res=0xDEADBEEF tag=5; no dmem write.
//  2. dmem[0x200]=0x12345678, empty sb. Ld addr 0x200 tag=1 -> rd_en same cycle;
//     next cycle res=0x12345678.
//  3. St 0x40 <- 1, then st 0x40 <- 2, then ld 0x40 -> res=2 (youngest match wins).
//  4. Four stores without commit -> rdy=0. One i_com_st -> next cycle wr_en=1 with first
//     addr/data; the cycle after, rdy=1.
//  5. Commit 2 stores while issuing loads every cycle -> no wr_en.
//     Stop loads -> two consecutive writes in program order.
//  6. Two committed stores pending, assert rst_n=0 for one cycle -> no wr_en ever;
//     rdy=1; a following ld reads the old dmem value.

Source files
------------

// File: rtl/ldst_exunit_pkg.sv
// ldst_exunit_pkg
// Shared widths and store-buffer geometry for the load/store execution unit,
// plus the word-address helper used by both the adder stage and the buffer.
// No ports.
package ldst_exunit_pkg;

    localparam int RV32_DATA_WIDTH = 32;
    localparam int RRF_ENT_SEL     = 6;
    localparam int SB_ENT_NUM      = 4;
    localparam int SB_ENT_SEL      = 2;
    localparam int WADDR_W         = RV32_DATA_WIDTH - 2;

    // Word-only accesses: the byte offset never takes part in matching or draining.
    function automatic logic [WADDR_W-1:0] word_addr(input logic [RV32_DATA_WIDTH-1:0] a);
        return a[RV32_DATA_WIDTH-1:2];
    endfunction

endpackage

// File: rtl/ldst_exunit_store_buffer.sv
// store_buffer
// In-order store buffer: circular storage with head/tail pointers, an entry
// count and a committed count. Committed entries drain from the head whenever
// no load owns the memory port. Also performs the youngest-match forward search
// for a load in the same cycle.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   i_push           accept a store at tail ({i_push_waddr, i_push_data})
//   i_commit         oldest uncommitted store retires
//   i_ld_acc         a load is using the memory port this cycle (blocks drain)
//   i_srch_waddr     word address of the load being searched
//   o_full           count == SB_ENT_NUM
//   o_drain          head entry is written to memory this cycle
//   o_drain_addr/_data  head entry contents
//   o_fwd_hit/_data  youngest matching entry for the load search
module store_buffer
    import ldst_exunit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WADDR_W-1:0]         i_push_waddr,
    input  logic [RV32_DATA_WIDTH-1:0] i_push_data,
    input  logic                       i_commit,
    input  logic                       i_ld_acc,
    input  logic [WADDR_W-1:0]         i_srch_waddr,
    output logic                       o_full,
    output logic                       o_drain,
    output logic [RV32_DATA_WIDTH-1:0] o_drain_addr,
    output logic [RV32_DATA_WIDTH-1:0] o_drain_data,
    output logic                       o_fwd_hit,
    output logic [RV32_DATA_WIDTH-1:0] o_fwd_data
);

    logic [WADDR_W-1:0]         r_waddr [SB_ENT_NUM];
    logic [RV32_DATA_WIDTH-1:0] r_data  [SB_ENT_NUM];
    logic [SB_ENT_SEL-1:0]      r_head;
    logic [SB_ENT_SEL-1:0]      r_tail;
    logic [SB_ENT_SEL:0]        r_count;
    logic [SB_ENT_SEL:0]        r_com_cnt;

    logic w_commit;

    // A commit with nothing left to commit is dropped rather than corrupting the count.
    assign w_commit = i_commit & (r_com_cnt < r_count);

    // Gated by rst_n so a reset cycle never leaks a write of a discarded entry.
    assign o_drain      = rst_n & (r_com_cnt != '0) & ~i_ld_acc;
    assign o_full       = (r_count == (SB_ENT_SEL+1)'(SB_ENT_NUM));
    assign o_drain_addr = {r_waddr[r_head], 2'b00};
    assign o_drain_data = r_data[r_head];

    // Walk from head (oldest) to tail-1 (youngest); a later match overrides,
    // so the youngest matching store wins.
    always_comb begin
        logic [SB_ENT_SEL-1:0] idx;
        idx        = '0;
        o_fwd_hit  = 1'b0;
        o_fwd_data = '0;
        for (int i = 0; i < SB_ENT_NUM; i++) begin
            idx = r_head + SB_ENT_SEL'(i);
            if (((SB_ENT_SEL+1)'(i) < r_count) && (r_waddr[idx] == i_srch_waddr)) begin
                o_fwd_hit  = 1'b1;
                o_fwd_data = r_data[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_com_cnt <= '0;
        end else begin
            if (i_push)
                r_tail <= r_tail + 1'b1;
            if (o_drain)
                r_head <= r_head + 1'b1;
            r_count   <= r_count + (SB_ENT_SEL+1)'(i_push) - (SB_ENT_SEL+1)'(o_drain);
            r_com_cnt <= r_com_cnt + (SB_ENT_SEL+1)'(w_commit) - (SB_ENT_SEL+1)'(o_drain);
        end
    end

    // Entry payload carries no reset; validity is defined by head/count alone.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_waddr[r_tail] <= i_push_waddr;
            r_data[r_tail]  <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && i_commit)
            assert (r_com_cnt < r_count)
            else $error("store_buffer: commit with no uncommitted entry");
    end

endmodule

// File: rtl/ldst_exunit.sv
// ldst_exunit
// Load/store execution unit. Computes rs1 + imm, arbitrates the single-port
// dmem between loads (priority) and store-buffer drains, and registers the
// load/store completion broadcasts.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   i_issue_vld / o_issue_rdy       issue handshake from the reservation station
//   i_rs1_srcopr, i_imm             address operands
//   i_rs2_srcopr                    store data
//   i_is_st, i_rrftag               op kind and destination/ROB tag
//   i_com_st                        oldest uncommitted store retires
//   o_dmem_*                        single-port dmem request (read or drain write)
//   i_dmem_rdata                    read data, one cycle after o_dmem_rd_en
//   o_exfin_ld, o_ex_ld_rrftag, o_exfin_ld_res   load completion
//   o_exfin_st, o_ex_st_rrftag                   store completion
module ldst_exunit
    import ldst_exunit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_issue_vld,
    output logic                       o_issue_rdy,
    input  logic [RV32_DATA_WIDTH-1:0] i_rs1_srcopr,
    input  logic [RV32_DATA_WIDTH-1:0] i_rs2_srcopr,
    input  logic [RV32_DATA_WIDTH-1:0] i_imm,
    input  logic                       i_is_st,
    input  logic [RRF_ENT_SEL-1:0]     i_rrftag,
    input  logic                       i_com_st,
    output logic                       o_dmem_rd_en,
    output logic                       o_dmem_wr_en,
    output logic [RV32_DATA_WIDTH-1:0] o_dmem_addr,
    output logic [RV32_DATA_WIDTH-1:0] o_dmem_wdata,
    input  logic [RV32_DATA_WIDTH-1:0] i_dmem_rdata,
    output logic                       o_exfin_ld,
    output logic [RRF_ENT_SEL-1:0]     o_ex_ld_rrftag,
    output logic [RV32_DATA_WIDTH-1:0] o_exfin_ld_res,
    output logic                       o_exfin_st,
    output logic [RRF_ENT_SEL-1:0]     o_ex_st_rrftag
);

    logic [RV32_DATA_WIDTH-1:0] w_addr;
    logic                       w_accept;
    logic                       w_ld_acc;
    logic                       w_st_acc;
    logic                       w_full;
    logic                       w_drain;
    logic [RV32_DATA_WIDTH-1:0] w_drain_addr;
    logic [RV32_DATA_WIDTH-1:0] w_drain_data;
    logic                       w_fwd_hit;
    logic [RV32_DATA_WIDTH-1:0] w_fwd_data;

    logic                       r_exfin_ld_p1;
    logic [RRF_ENT_SEL-1:0]     r_ld_tag_p1;
    logic                       r_ld_hit_p1;
    logic [RV32_DATA_WIDTH-1:0] r_ld_fwd_p1;
    logic                       r_exfin_st_p1;
    logic [RRF_ENT_SEL-1:0]     r_st_tag_p1;

    // ---- stage p0: address, accept, port arbitration ----
    assign w_addr      = i_rs1_srcopr + i_imm;
    assign o_issue_rdy = ~w_full;
    assign w_accept    = rst_n & i_issue_vld & o_issue_rdy;
    assign w_ld_acc    = w_accept & ~i_is_st;
    assign w_st_acc    = w_accept &  i_is_st;

    store_buffer u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_st_acc),
        .i_push_waddr (word_addr(w_addr)),
        .i_push_data  (i_rs2_srcopr),
        .i_commit     (i_com_st),
        .i_ld_acc     (w_ld_acc),
        .i_srch_waddr (word_addr(w_addr)),
        .o_full       (w_full),
        .o_drain      (w_drain),
        .o_drain_addr (w_drain_addr),
        .o_drain_data (w_drain_data),
        .o_fwd_hit    (w_fwd_hit),
        .o_fwd_data   (w_fwd_data)
    );

    // The drain is already suppressed on a load cycle, so the two enables are exclusive.
    assign o_dmem_rd_en = w_ld_acc;
    assign o_dmem_wr_en = w_drain;
    assign o_dmem_addr  = w_ld_acc ? w_addr : (w_drain ? w_drain_addr : '0);
    assign o_dmem_wdata = w_drain ? w_drain_data : '0;

    // ---- stage p1: completion registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exfin_ld_p1 <= 1'b0;
            r_ld_tag_p1   <= '0;
            r_ld_hit_p1   <= 1'b0;
            r_ld_fwd_p1   <= '0;
            r_exfin_st_p1 <= 1'b0;
            r_st_tag_p1   <= '0;
        end else begin
            r_exfin_ld_p1 <= w_ld_acc;
            r_exfin_st_p1 <= w_st_acc;
            if (w_ld_acc) begin
                r_ld_tag_p1 <= i_rrftag;
                r_ld_hit_p1 <= w_fwd_hit;
                r_ld_fwd_p1 <= w_fwd_data;
            end
            if (w_st_acc)
                r_st_tag_p1 <= i_rrftag;
        end
    end

    assign o_exfin_ld     = r_exfin_ld_p1;
    assign o_ex_ld_rrftag = r_ld_tag_p1;
    assign o_exfin_ld_res = r_exfin_ld_p1 ? (r_ld_hit_p1 ? r_ld_fwd_p1 : i_dmem_rdata) : '0;
    assign o_exfin_st     = r_exfin_st_p1;
    assign o_ex_st_rrftag = r_st_tag_p1;

    always_ff @(posedge clk) begin
        if (rst_n && i_issue_vld)
            assert (o_issue_rdy)
            else $error("ldst_exunit: issue while not ready");
    end

endmodule

// File: tb/tb_ldst_exunit.sv
module tb_ldst_exunit;
    import ldst_exunit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_issue_vld = 1'b0;
    logic        o_issue_rdy;
    logic [31:0] i_rs1_srcopr = '0;
    logic [31:0] i_rs2_srcopr = '0;
    logic [31:0] i_imm = '0;
    logic        i_is_st = 1'b0;
    logic [5:0]  i_rrftag = '0;
    logic        i_com_st = 1'b0;
    logic        o_dmem_rd_en;
    logic        o_dmem_wr_en;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [31:0] i_dmem_rdata = '0;
    logic        o_exfin_ld;
    logic [5:0]  o_ex_ld_rrftag;
    logic [31:0] o_exfin_ld_res;
    logic        o_exfin_st;
    logic [5:0]  o_ex_st_rrftag;

    always #5 clk = ~clk;

    ldst_exunit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_issue_vld    (i_issue_vld),
        .o_issue_rdy    (o_issue_rdy),
        .i_rs1_srcopr   (i_rs1_srcopr),
        .i_rs2_srcopr   (i_rs2_srcopr),
        .i_imm          (i_imm),
        .i_is_st        (i_is_st),
        .i_rrftag       (i_rrftag),
        .i_com_st       (i_com_st),
        .o_dmem_rd_en   (o_dmem_rd_en),
        .o_dmem_wr_en   (o_dmem_wr_en),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_wdata   (o_dmem_wdata),
        .i_dmem_rdata   (i_dmem_rdata),
        .o_exfin_ld     (o_exfin_ld),
        .o_ex_ld_rrftag (o_ex_ld_rrftag),
        .o_exfin_ld_res (o_exfin_ld_res),
        .o_exfin_st     (o_exfin_st),
        .o_ex_st_rrftag (o_ex_st_rrftag)
    );

    // dmem model: 256 words, preloaded on the first edge, 1-cycle read latency
    int          cyc = 0;
    logic [31:0] mem    [0:255];
    logic [31:0] shadow [0:255];  // architectural memory in program order

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 128) ? 32'h12345678 : 32'h0;
        end else begin
            if (o_dmem_rd_en) i_dmem_rdata <= mem[o_dmem_addr[9:2]];
            if (o_dmem_wr_en) mem[o_dmem_addr[9:2]] <= o_dmem_wdata;
        end
    end

    // scoreboard
    typedef struct { logic [5:0] tag; logic [31:0] res; int cyc; } ld_exp_t;
    typedef struct { logic [5:0] tag; int cyc; } st_exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_exp_t;
    ld_exp_t ldq[$];
    st_exp_t stq[$];
    wr_exp_t wq[$];

    int checks = 0;
    int errors = 0;
    bit no_wr = 1'b0;
    int n_uncom = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (o_dmem_rd_en && o_dmem_wr_en) chk("rd_wr_exclusive", 1, 0);
        if (o_exfin_ld) begin
            if (ldq.size() == 0) chk("exfin_ld_unexpected", 1, 0);
            else begin
                ld_exp_t e;
                e = ldq.pop_front();
                chk("ld_tag", 32'(o_ex_ld_rrftag), 32'(e.tag));
                chk("ld_res", o_exfin_ld_res, e.res);
                chk("ld_latency", cyc, e.cyc);
            end
        end
        if (o_exfin_st) begin
            if (stq.size() == 0) chk("exfin_st_unexpected", 1, 0);
            else begin
                st_exp_t s;
                s = stq.pop_front();
                chk("st_tag", 32'(o_ex_st_rrftag), 32'(s.tag));
                chk("st_latency", cyc, s.cyc);
            end
        end
        if (o_dmem_wr_en) begin
            if (no_wr) chk("wr_en_forbidden", 1, 0);
            else if (wq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                wr_exp_t w;
                w = wq.pop_front();
                chk("wr_addr", o_dmem_addr, w.addr);
                chk("wr_data", o_dmem_wdata, w.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        i_issue_vld = 1'b0;
        i_com_st    = 1'b0;
        #1;
    endtask

    task automatic issue(input bit st, input logic [31:0] rs1, input logic [31:0] imm,
                         input logic [31:0] rs2, input logic [5:0] tag,
                         input bit use_exp, input logic [31:0] exp, input bit com);
        logic [31:0] a;
        logic [31:0] e;
        int w;
        w = 0;
        while (!o_issue_rdy && w < 20) begin step(); w++; end
        if (!o_issue_rdy) begin
            chk("issue_rdy_timeout", 0, 1);
            return;
        end
        a = rs1 + imm;
        i_issue_vld = 1'b1; i_is_st = st; i_rs1_srcopr = rs1; i_imm = imm;
        i_rs2_srcopr = rs2; i_rrftag = tag; i_com_st = com;
        if (com) n_uncom--;
        #1;
        if (st) begin
            chk("st_no_rd_en", 32'(o_dmem_rd_en), 0);
            stq.push_back('{tag, cyc + 1});
            wq.push_back('{{a[31:2], 2'b00}, rs2});
            shadow[a[9:2]] = rs2;
            n_uncom++;
        end else begin
            chk("ld_rd_en", 32'(o_dmem_rd_en), 1);
            chk("ld_addr", o_dmem_addr, a);
            chk("ld_no_wr_en", 32'(o_dmem_wr_en), 0);
            e = use_exp ? exp : shadow[a[9:2]];
            ldq.push_back('{tag, e, cyc + 1});
        end
        step();
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        while (wq.size() > 0 && n < 100) begin
            if (n_uncom > 0) begin
                i_com_st = 1'b1;
                n_uncom--;
            end
            step();
            n++;
        end
        chk("drain_done", wq.size(), 0);
    endtask

    typedef struct {
        bit          is_st;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] rs2;
        logic [5:0]  tag;
        logic [31:0] exp;
    } vec_t;
    vec_t vec [9];

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = (i == 128) ? 32'h12345678 : 32'h0;

        vec[0] = '{1'b0, 32'h200, 32'h0,        32'h0,        6'd1,  32'h12345678};
        vec[1] = '{1'b1, 32'h100, 32'h4,        32'hDEADBEEF, 6'd3,  32'h0};
        vec[2] = '{1'b0, 32'h104, 32'h0,        32'h0,        6'd5,  32'hDEADBEEF};
        vec[3] = '{1'b1, 32'h40,  32'h0,        32'h1,        6'd7,  32'h0};
        vec[4] = '{1'b1, 32'h3C,  32'h4,        32'h2,        6'd8,  32'h0};
        vec[5] = '{1'b0, 32'h40,  32'h0,        32'h0,        6'd9,  32'h2};
        vec[6] = '{1'b0, 32'h42,  32'h0,        32'h0,        6'd10, 32'h2};
        vec[7] = '{1'b0, 32'h44,  32'h0,        32'h0,        6'd11, 32'h0};
        vec[8] = '{1'b0, 32'h108, 32'hFFFFFFF8, 32'h0,        6'd12, 32'h0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_rdy",      32'(o_issue_rdy), 1);
        chk("rst_exfin_ld", 32'(o_exfin_ld), 0);
        chk("rst_exfin_st", 32'(o_exfin_st), 0);
        chk("rst_rd_en",    32'(o_dmem_rd_en), 0);
        chk("rst_wr_en",    32'(o_dmem_wr_en), 0);
        chk("rst_addr",     o_dmem_addr, 0);
        chk("rst_ld_res",   o_exfin_ld_res, 0);
        chk("rst_ld_tag",   32'(o_ex_ld_rrftag), 0);

        // table: plain read, store->load forward, youngest match, offsets
        no_wr = 1'b1;
        for (int k = 0; k < 9; k++)
            issue(vec[k].is_st, vec[k].rs1, vec[k].imm, vec[k].rs2, vec[k].tag, 1'b1, vec[k].exp, 1'b0);
        no_wr = 1'b0;
        drain_all();

        // full buffer blocks issue; one commit drains the oldest entry
        no_wr = 1'b1;
        for (int k = 0; k < 4; k++)
            issue(1'b1, 32'h300 + 32'(4 * k), 32'h0, 32'hA0 + 32'(k), 6'(20 + k), 1'b0, 32'h0, 1'b0);
        chk("full_rdy", 32'(o_issue_rdy), 0);
        no_wr = 1'b0;
        i_com_st = 1'b1;
        n_uncom--;
        step();
        chk("drain_wr_en",   32'(o_dmem_wr_en), 1);
        chk("drain_addr",    o_dmem_addr, 32'h300);
        chk("drain_wdata",   o_dmem_wdata, 32'hA0);
        step();
        chk("rdy_after_drain", 32'(o_issue_rdy), 1);
        drain_all();

        // loads own the port: committed stores wait until loads stop
        no_wr = 1'b1;
        issue(1'b1, 32'h380, 32'h0, 32'h55, 6'd30, 1'b0, 32'h0, 1'b0);
        issue(1'b1, 32'h384, 32'h0, 32'h66, 6'd31, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 6; k++)
            issue(1'b0, (k % 2 == 0) ? 32'h380 : 32'h384, 32'h0, 32'h0, 6'(32 + k), 1'b0, 32'h0, k < 2);
        no_wr = 1'b0;
        chk("drain1_wr_en", 32'(o_dmem_wr_en), 1);
        chk("drain1_addr",  o_dmem_addr, 32'h380);
        step();
        chk("drain2_wr_en", 32'(o_dmem_wr_en), 1);
        chk("drain2_addr",  o_dmem_addr, 32'h384);
        step();
        chk("drain_idle",   32'(o_dmem_wr_en), 0);

        // reset with committed stores pending discards them
        no_wr = 1'b1;
        issue(1'b1, 32'h3C0, 32'h0, 32'h77, 6'd40, 1'b0, 32'h0, 1'b0);
        issue(1'b1, 32'h3C4, 32'h0, 32'h88, 6'd41, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 32'h3C0, 32'h0, 32'h0,  6'd42, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 32'h3C4, 32'h0, 32'h0,  6'd43, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wq.delete();
        n_uncom = 0;
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
        repeat (3) step();
        chk("post_rst_rdy", 32'(o_issue_rdy), 1);
        chk("post_rst_mem", mem[240], 32'h0);
        issue(1'b0, 32'h3C0, 32'h0, 32'h0, 6'd44, 1'b1, 32'h0, 1'b0);
        repeat (3) step();
        no_wr = 1'b0;

        chk("ldq_empty", ldq.size(), 0);
        chk("stq_empty", stq.size(), 0);
        chk("wq_empty",  wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
